// File: rtl/wall_scheduler.sv
// Wall spawn sequencer and round-robin arbiter for the shared VGA draw/erase datapath.
// Spawns launch into the lowest free slot; the drawer is granted round-robin, one job at a time.
module wall_scheduler #(
  parameter int unsigned NUM_WALLS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [CNT_W-1:0]     interval,
  input  logic [NUM_WALLS-1:0] wall_busy,
  input  logic [NUM_WALLS-1:0] draw_req,
  input  logic                 draw_done,
  output logic [NUM_WALLS-1:0] wall_go,
  output logic [NUM_WALLS-1:0] draw_grant,
  output logic [CNT_W-1:0]     spawn_count,
  output logic                 overflow
);

  localparam int unsigned IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;
  localparam logic [NUM_WALLS-1:0] ONE_HOT0 = {{(NUM_WALLS-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [NUM_WALLS-1:0] reserved_q, reserved_d;
  logic [NUM_WALLS-1:0] go_q, go_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     ivl_m1;
  logic                 advance, spawn_due;
  logic [NUM_WALLS-1:0] free;

  logic [0:0]           state_q, state_d;
  logic [NUM_WALLS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  // Spawn path: timer, slot allocation, reservation and statistics.
  always_comb begin
    ivl_m1     = (interval == '0) ? '0 : interval - CNT_W'(1);
    advance    = frame_tick & enable;
    spawn_due  = advance && (timer_q == ivl_m1);
    timer_d    = timer_q;
    if (advance) timer_d = spawn_due ? '0 : timer_q + CNT_W'(1);
    free       = ~wall_busy & ~reserved_q;
    go_d       = '0;
    // Descending scan so the lowest free slot is the last (winning) assignment.
    for (int i = int'(NUM_WALLS) - 1; i >= 0; i--) begin
      if (spawn_due && free[i]) go_d = ONE_HOT0 << i;
    end
    // Reservation covers the gap until the wall controller raises busy.
    reserved_d = (reserved_q & ~wall_busy) | go_d;
    overflow_d = overflow_q | (spawn_due && (free == '0));
    count_d    = count_q;
    if ((go_d != '0) && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // Arbiter: first requester after rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_WALLS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_WALLS) cand = cand - NUM_WALLS;
      if (!pick_found && draw_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d     = ONE_HOT0 << pick_idx;
          grant_idx_d = pick_idx;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (draw_done) begin
          grant_d  = '0;
          rr_ptr_d = grant_idx_q;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q     <= '0;
      reserved_q  <= '0;
      go_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= IDX_W'(NUM_WALLS - 1);
    end else begin
      timer_q     <= timer_d;
      reserved_q  <= reserved_d;
      go_q        <= go_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign wall_go     = go_q;
  assign draw_grant  = grant_q;
  assign spawn_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wall_scheduler.sv
// Directed self-checking bench for wall_scheduler: spawn timing, slot allocation,
// overflow, enable gating and round-robin draw arbitration.
module tb_wall_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       frame_tick;
  logic [7:0] interval;
  logic [3:0] wall_busy;
  logic [3:0] draw_req;
  logic       draw_done;
  logic [3:0] wall_go;
  logic [3:0] draw_grant;
  logic [7:0] spawn_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  wall_scheduler #(.NUM_WALLS(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_tick (frame_tick),
    .interval   (interval),
    .wall_busy  (wall_busy),
    .draw_req   (draw_req),
    .draw_done  (draw_done),
    .wall_go    (wall_go),
    .draw_grant (draw_grant),
    .spawn_count(spawn_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; return 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle frame_tick; on return the registered wall_go for that tick is visible.
  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; frame_tick = 1'b0; interval = 8'd3;
    wall_busy = '0; draw_req = '0; draw_done = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic done_pulse();
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
  endtask

  logic [3:0] acc;
  logic [3:0] rot_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_go", wall_go, 0);
    check("rst_grant", draw_grant, 0);
    check("rst_count", spawn_count, 0);
    check("rst_ovf", overflow, 0);

    // interval=3, ticks every 10 clocks, busy never rises
    acc = '0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 3) begin
        check("go_tick3", wall_go, 4'b0001);
        step(1);
        check("go_one_cycle", wall_go, 0);
        step(8);
      end else if (t == 6) begin
        check("go_tick6_slot1", wall_go, 4'b0010);
      end else begin
        acc |= wall_go;
        step(9);
      end
    end
    check("go_quiet_between", acc, 0);
    check("count_two", spawn_count, 2);

    // All slots busy: spawn dropped, sticky overflow
    do_reset();
    interval = 8'd1; wall_busy = 4'b1111;
    tick();
    check("ovf_no_go", wall_go, 0);
    check("ovf_set", overflow, 1);
    check("ovf_count", spawn_count, 0);
    wall_busy = '0;
    step(3);
    check("ovf_sticky", overflow, 1);

    // Reservation released once busy is seen
    do_reset();
    interval = 8'd1;
    tick();
    check("res_first", wall_go, 4'b0001);
    wall_busy = 4'b0001;
    step(2);
    tick();
    check("res_skip_busy", wall_go, 4'b0010);
    wall_busy = 4'b0000;
    step(1);
    tick();
    check("res_reuse0", wall_go, 4'b0001);

    // interval=0 acts as 1; fifth spawn finds no free slot
    do_reset();
    interval = 8'd0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("ivl0_go", wall_go, 4'b0001 << t);
    end
    check("ivl0_no_ovf", overflow, 0);
    tick();
    check("ivl0_full_go", wall_go, 0);
    check("ivl0_full_ovf", overflow, 1);
    check("ivl0_count", spawn_count, 4);

    // Enable low freezes the timer
    do_reset();
    tick(); tick();
    enable = 1'b0;
    acc = '0;
    repeat (3) begin tick(); acc |= wall_go; end
    check("en_frozen", acc, 0);
    enable = 1'b1;
    tick();
    check("en_resume", wall_go, 4'b0001);

    // Lowering interval below timer wraps instead of firing early
    do_reset();
    interval = 8'd10;
    repeat (5) tick();
    interval = 8'd3;
    acc = '0;
    repeat (253) begin tick(); acc |= wall_go; end
    check("wrap_no_early", acc, 0);
    tick();
    check("wrap_fire", wall_go, 4'b0001);

    // Arbiter: basic grant, hold, idle gap, rotation
    do_reset();
    draw_req = 4'b1010;
    step(1);
    check("arb_first", draw_grant, 4'b0010);
    draw_req = 4'b0000;
    step(3);
    check("arb_hold", draw_grant, 4'b0010);
    draw_req = 4'b1010;
    done_pulse();
    check("arb_release", draw_grant, 0);
    step(1);
    check("arb_next", draw_grant, 4'b1000);

    do_reset();
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    draw_req = 4'b1111;
    step(1);
    check("rr_0", draw_grant, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      done_pulse();
      check("rr_gap", draw_grant, 0);
      step(1);
      check("rr_rot", draw_grant, rot_exp[k]);
    end

    // Reset mid-operation with grant=0100 and timer=2
    do_reset();
    interval = 8'd5;
    draw_req = 4'b0010;
    step(1);
    done_pulse();
    draw_req = 4'b0100;
    step(1);
    check("mid_grant", draw_grant, 4'b0100);
    tick(); tick();
    reset = 1'b1; draw_req = '0; interval = 8'd3;
    step(1);
    check("mid_rst_grant", draw_grant, 0);
    check("mid_rst_go", wall_go, 0);
    reset = 1'b0;
    draw_req = 4'b1111;
    step(1);
    check("mid_next_grant", draw_grant, 4'b0001);
    tick();
    check("mid_timer_zero", wall_go, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
